// File: rtl/imem_line_interface_pkg.sv
// rtl/imem_line_interface_pkg.sv - shared types, defaults and helpers for the line-fetch instruction memory
package imem_pkg;

    localparam int DEF_MEM_WORD_WIDTH = 32;
    localparam int DEF_MEM_SIZE       = 16384;
    localparam int DEF_LINE_WORDS     = 4;
    localparam int DEF_ADDR_SIZE      = 40;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESP
    } state_e;

    typedef struct packed {
        logic                                valid;
        logic                                xcpt;
        logic [DEF_LINE_WORDS*32-1:0]        data;
    } resp_t;

    // Clears the in-line word offset so every fill starts on a line boundary.
    function automatic logic [31:0] line_base(input logic [31:0] word_idx,
                                              input int unsigned line_words);
        return word_idx & ~(line_words - 32'd1);
    endfunction

endpackage

// File: rtl/imem_line_interface_if.sv
// rtl/imem_line_interface_if.sv - fetch request/response bundle between icache path and line memory
interface imem_line_interface_if #(
    parameter int ADDR_SIZE  = 40,
    parameter int LINE_WORDS = 4
) ();
    logic                     req_valid_i;
    logic [ADDR_SIZE-1:0]     req_addr_i;
    logic                     req_kill_i;
    logic                     req_ready_o;
    logic                     resp_valid_o;
    logic [32*LINE_WORDS-1:0] resp_data_o;
    logic                     resp_xcpt_o;

    modport master (
        output req_valid_i, req_addr_i, req_kill_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_xcpt_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_kill_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_xcpt_o
    );
endinterface

// File: rtl/imem_line_interface_sram.sv
// rtl/imem_line_interface_sram.sv - single-port synchronous RAM with registered read data
module imem_sram #(
    parameter int MEM_DEPTH = 4096,
    parameter int WIDTH     = 32,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // One access per cycle; a write wins the port and the read register keeps its old value.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_line_interface.sv
// rtl/imem_line_interface.sv - line-fill fetch FSM with debugger port arbitration over one SRAM
module imem_line_interface
    import imem_pkg::*;
#(
    parameter int MEM_WORD_WIDTH = DEF_MEM_WORD_WIDTH,
    parameter int MEM_SIZE       = DEF_MEM_SIZE,
    parameter int LINE_WORDS     = DEF_LINE_WORDS,
    parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
    localparam int MEM_DEPTH     = MEM_SIZE / 4,
    localparam int ADDRS_WIDTH   = $clog2(MEM_DEPTH)
) (
    input  logic                      clk_extern_i,
    input  logic                      rst_extern_i,
    input  logic                      dbgr_we_i,
    input  logic                      dbgr_re_i,
    input  logic [ADDRS_WIDTH-1:0]    dbgr_addr_i,
    input  logic [MEM_WORD_WIDTH-1:0] dbgr_data_i,
    output logic                      dbgr_valid_o,
    output logic [MEM_WORD_WIDTH-1:0] dbgr_data_o,
    imem_line_interface_if.slave      fetch
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int CNT_W = (OFF > 0) ? OFF : 1;
    localparam int LINE_W = MEM_WORD_WIDTH * LINE_WORDS;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDRS_WIDTH-1:0]    base_q, base_d;
    logic                      xcpt_q, xcpt_d;
    logic                      cap_q;
    logic [CNT_W-1:0]          cap_idx_q;
    logic                      dbg_pend_q;
    logic [MEM_WORD_WIDTH-1:0] dbg_hold_q;
    logic [LINE_W-1:0]         out_q;
    logic [LINE_W-1:0]         resp_line;
    logic [MEM_WORD_WIDTH-1:0] line_q [LINE_WORDS];

    logic                      accept, out_of_range, dbg_access, beat_fire, last_beat;
    logic                      ram_re;
    logic [ADDRS_WIDTH-1:0]    ram_addr;
    logic [MEM_WORD_WIDTH-1:0] ram_rdata;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^fetch.req_addr_i[1:0];
    assign out_of_range     = |fetch.req_addr_i[ADDR_SIZE-1:ADDRS_WIDTH+2];
    assign accept           = fetch.req_valid_i & fetch.req_ready_o;
    assign dbg_access       = dbgr_we_i | dbgr_re_i;
    assign last_beat        = (cnt_q == CNT_W'(LINE_WORDS - 1));
    assign beat_fire        = (state_q == FILL) & ~dbg_access & ~fetch.req_kill_i & ~rst_extern_i;

    assign ram_re   = (dbgr_re_i & ~dbgr_we_i) | beat_fire;
    assign ram_addr = dbg_access ? dbgr_addr_i : base_q + ADDRS_WIDTH'(cnt_q);

    imem_sram #(
        .MEM_DEPTH (MEM_DEPTH),
        .WIDTH     (MEM_WORD_WIDTH)
    ) u_sram (
        .clk_i   (clk_extern_i),
        .we_i    (dbgr_we_i),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (dbgr_data_i),
        .rdata_o (ram_rdata)
    );

    // Next-state logic: accept, beat sequencing with debugger stalls, kill and the single response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        xcpt_d  = xcpt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    xcpt_d  = out_of_range;
                    cnt_d   = '0;
                    base_d  = ADDRS_WIDTH'(line_base(32'(fetch.req_addr_i[ADDRS_WIDTH+1:2]), LINE_WORDS));
                    state_d = out_of_range ? RESP : FILL;
                end
            end
            FILL: begin
                if (fetch.req_kill_i) begin
                    state_d = IDLE;
                end else if (beat_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters, debugger read tracking and the held response line.
    always_ff @(posedge clk_extern_i) begin
        if (rst_extern_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            xcpt_q     <= 1'b0;
            cap_q      <= 1'b0;
            cap_idx_q  <= '0;
            dbg_pend_q <= 1'b0;
            dbg_hold_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            xcpt_q     <= xcpt_d;
            cap_q      <= beat_fire;
            cap_idx_q  <= cnt_q;
            dbg_pend_q <= dbgr_re_i & ~dbgr_we_i;
            if (dbg_pend_q) begin
                dbg_hold_q <= ram_rdata;
            end
            if (state_q == RESP) begin
                out_q <= resp_line;
            end
        end
    end

    // Line buffer: each beat's read data lands in its slot the cycle after the beat.
    always_ff @(posedge clk_extern_i) begin
        if (cap_q) begin
            line_q[cap_idx_q] <= ram_rdata;
        end
    end

    // The last beat's word is still in the RAM output register during RESP, so it bypasses the buffer.
    always_comb begin
        resp_line = '0;
        if (!xcpt_q) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                resp_line[i*MEM_WORD_WIDTH +: MEM_WORD_WIDTH] = (i == LINE_WORDS - 1) ? ram_rdata : line_q[i];
            end
        end
    end

    assign fetch.req_ready_o  = (state_q == IDLE) & ~rst_extern_i;
    assign fetch.resp_valid_o = (state_q == RESP);
    assign fetch.resp_xcpt_o  = (state_q == RESP) & xcpt_q;
    assign fetch.resp_data_o  = (state_q == RESP) ? resp_line : out_q;

    assign dbgr_valid_o = dbg_pend_q;
    assign dbgr_data_o  = dbg_pend_q ? ram_rdata : dbg_hold_q;
endmodule

// File: tb/tb_imem_line_interface.sv
// tb/tb_imem_line_interface.sv - scoreboard bench for the line-fetch instruction memory
module tb_imem_line_interface;
    import imem_pkg::*;

    typedef struct {
        resp_t r;
        int    cyc;
    } sb_t;

    typedef struct {
        logic [31:0] d;
        int          cyc;
    } dq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dbgr_we = 1'b0;
    logic        dbgr_re = 1'b0;
    logic [11:0] dbgr_addr = '0;
    logic [31:0] dbgr_wdata = '0;
    logic        dbgr_valid;
    logic [31:0] dbgr_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    sb_t         sb[$];
    dq_t         dq[$];
    logic [31:0] mem_m [4096];

    logic         prev_resp = 1'b0;
    logic         prev_dbg  = 1'b0;
    logic [127:0] last_resp = '0;
    logic [31:0]  last_dbg  = '0;

    imem_line_interface_if #(.ADDR_SIZE(40), .LINE_WORDS(4)) fif ();

    imem_line_interface #(
        .MEM_WORD_WIDTH (32),
        .MEM_SIZE       (16384),
        .LINE_WORDS     (4),
        .ADDR_SIZE      (40)
    ) dut (
        .clk_extern_i (clk),
        .rst_extern_i (rst),
        .dbgr_we_i    (dbgr_we),
        .dbgr_re_i    (dbgr_re),
        .dbgr_addr_i  (dbgr_addr),
        .dbgr_data_i  (dbgr_wdata),
        .dbgr_valid_o (dbgr_valid),
        .dbgr_data_o  (dbgr_rdata),
        .fetch        (fif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] line_of(input int base);
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_resp <= 1'b0;
            prev_dbg  <= 1'b0;
        end else begin
            if (prev_resp) begin
                check("ready_after_resp", 128'(fif.req_ready_o), 128'(1));
                check("resp_data_hold", fif.resp_data_o, last_resp);
            end
            if (fif.resp_valid_o) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 128'(1), 128'(0));
                end else begin
                    check("resp_cycle", 128'(cyc), 128'(sb[0].cyc));
                    check("resp_xcpt", 128'(fif.resp_xcpt_o), 128'(sb[0].r.xcpt));
                    check("resp_data", fif.resp_data_o, sb[0].r.data);
                    void'(sb.pop_front());
                end
                last_resp <= fif.resp_data_o;
            end
            prev_resp <= fif.resp_valid_o;

            if (prev_dbg && !dbgr_valid) begin
                check("dbg_data_hold", 128'(dbgr_rdata), 128'(last_dbg));
            end
            if (dbgr_valid) begin
                if (dq.size() == 0) begin
                    check("dbg_unexpected", 128'(1), 128'(0));
                end else begin
                    check("dbg_cycle", 128'(cyc), 128'(dq[0].cyc));
                    check("dbg_data", 128'(dbgr_rdata), 128'(dq[0].d));
                    void'(dq.pop_front());
                end
                last_dbg <= dbgr_rdata;
            end
            prev_dbg <= dbgr_valid;
        end
    end

    task automatic dbg_write(input int a, input logic [31:0] d);
        dbgr_we = 1'b1; dbgr_addr = 12'(a); dbgr_wdata = d;
        mem_m[a] = d;
        @(negedge clk);
        dbgr_we = 1'b0;
    endtask

    task automatic dbg_read(input int a);
        dbgr_re = 1'b1; dbgr_addr = 12'(a);
        dq.push_back('{d: mem_m[a], cyc: cyc + 1});
        @(negedge clk);
        dbgr_re = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50 && !fif.req_ready_o; i++) @(negedge clk);
        check("ready_wait", 128'(fif.req_ready_o), 128'(1));
    endtask

    // Drives one request; returns at the negedge of the first cycle after acceptance.
    task automatic do_fetch(input logic [39:0] addr, input logic [127:0] exp_data,
                            input logic exp_x, input int lat, input bit expect_resp);
        wait_ready();
        fif.req_valid_i = 1'b1;
        fif.req_addr_i  = addr;
        if (expect_resp) begin
            sb.push_back('{r: '{valid: 1'b1, xcpt: exp_x, data: exp_data}, cyc: cyc + lat});
        end
        @(negedge clk);
        fif.req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || dq.size() != 0); i++) @(negedge clk);
        check("drain", 128'(sb.size() + dq.size()), 128'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 128'(fif.req_ready_o), 128'(0));
        check({tag, "_resp_valid"}, 128'(fif.resp_valid_o), 128'(0));
        check({tag, "_resp_xcpt"}, 128'(fif.resp_xcpt_o), 128'(0));
        check({tag, "_resp_data"}, fif.resp_data_o, 128'(0));
        check({tag, "_dbg_valid"}, 128'(dbgr_valid), 128'(0));
        check({tag, "_dbg_data"}, 128'(dbgr_rdata), 128'(0));
    endtask

    initial begin
        fif.req_valid_i = 1'b0;
        fif.req_addr_i  = '0;
        fif.req_kill_i  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("reset_release_ready", 128'(fif.req_ready_o), 128'(1));

        for (int i = 0; i < 16; i++) dbg_write(i, 32'h1000 + 32'(i));
        for (int i = 4092; i < 4096; i++) dbg_write(i, 32'hF000 + 32'(i));

        do_fetch(40'h14, line_of(4), 1'b0, 5, 1'b1);
        wait_drain();
        do_fetch(40'h1_0000_0000, 128'(0), 1'b1, 1, 1'b1);
        wait_drain();
        do_fetch(40'h4000, 128'(0), 1'b1, 1, 1'b1);
        wait_drain();
        do_fetch(40'h3FFC, line_of(4092), 1'b0, 5, 1'b1);
        wait_drain();
        do_fetch(40'h17, line_of(4), 1'b0, 5, 1'b1);
        wait_drain();

        do_fetch(40'h20, {mem_m[11], mem_m[10], 32'hAAAA0009, mem_m[8]}, 1'b0, 7, 1'b1);
        dbg_write(9, 32'hAAAA0009);
        @(negedge clk);
        dbg_write(8, 32'hBBBB0008);
        wait_drain();
        dbg_read(8);
        wait_drain();

        do_fetch(40'h40, 128'(0), 1'b0, 0, 1'b0);
        @(negedge clk);
        fif.req_kill_i = 1'b1;
        @(negedge clk);
        fif.req_kill_i = 1'b0;
        check("kill_ready", 128'(fif.req_ready_o), 128'(1));
        repeat (6) @(negedge clk);
        do_fetch(40'h0, line_of(0), 1'b0, 5, 1'b1);
        wait_drain();

        do_fetch(40'h2_0000_0040, 128'(0), 1'b1, 1, 1'b1);
        fif.req_kill_i = 1'b1;
        @(negedge clk);
        fif.req_kill_i = 1'b0;
        wait_drain();

        dbg_write(5, 32'hDEADBEEF);
        dbg_read(5);
        wait_drain();
        dbgr_we = 1'b1; dbgr_re = 1'b1; dbgr_addr = 12'd6; dbgr_wdata = 32'h12345678;
        mem_m[6] = 32'h12345678;
        @(negedge clk);
        dbgr_we = 1'b0; dbgr_re = 1'b0;
        repeat (2) @(negedge clk);
        dbg_read(6);
        wait_drain();

        do_fetch(40'h0, line_of(0), 1'b0, 6, 1'b1);
        dbg_read(5);
        wait_drain();

        do_fetch(40'h10, 128'(0), 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midfill_reset");
        rst = 1'b0;
        @(negedge clk);
        check("midfill_release_ready", 128'(fif.req_ready_o), 128'(1));
        repeat (8) @(negedge clk);
        do_fetch(40'h34, line_of(12), 1'b0, 5, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
